// File: rtl/gpu_op_arbiter_pkg.sv
// Shared types for the GPU draw-op arbiter: the draw-op word, the arbiter FSM states
// and the requester-count ceiling.
package gpu_op_arbiter_pkg;

  localparam int GPU_ARB_MAX_REQ = 8;

  typedef struct packed {
    logic [3:0] kind;
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] color;
  } gpu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } gpu_arb_state_t;

endpackage

// File: rtl/gpu_op_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of valid searching rr_ptr+1, rr_ptr+2, ...
// wrapping, with rr_ptr itself checked last.
module rr_arbiter_pick #(
  parameter int REQ_COUNT = 2
) (
  input  logic [REQ_COUNT-1:0]         valid,
  input  logic [$clog2(REQ_COUNT)-1:0] rr_ptr,
  output logic [$clog2(REQ_COUNT)-1:0] sel,
  output logic                         any
);

  localparam int PTR_W = $clog2(REQ_COUNT);

  int idx;

  // Walk from the farthest candidate back to the nearest so the nearest match wins.
  always_comb begin
    sel = rr_ptr;
    any = 1'b0;
    idx = 0;
    for (int k = REQ_COUNT; k >= 1; k--) begin
      idx = (int'(rr_ptr) + k) % REQ_COUNT;
      if (valid[idx]) begin
        sel = idx[PTR_W-1:0];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpu_op_arbiter.sv
// Round-robin arbiter sharing one GPU draw-op port among REQ_COUNT requesters, with lockable bursts.
// Optional transfer counter on op_count when GPU_OP_ARBITER_STATS_EN is defined.
module gpu_op_arbiter
  import gpu_op_arbiter_pkg::*;
#(
  parameter int REQ_COUNT   = 2,
  parameter int STATS_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  gpu_op_t                req_op [REQ_COUNT],
  input  logic [REQ_COUNT-1:0]   req_valid,
  input  logic [REQ_COUNT-1:0]   req_lock,
  output logic [REQ_COUNT-1:0]   req_ready,
  output logic [REQ_COUNT-1:0]   grant,
  output gpu_op_t                op,
  output logic                   op_valid,
  input  logic                   op_ready,
  output logic                   busy
`ifdef GPU_OP_ARBITER_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0] op_count
`endif
);

  localparam int PTR_W = $clog2(REQ_COUNT);

  if (REQ_COUNT < 2 || REQ_COUNT > GPU_ARB_MAX_REQ || STATS_WIDTH < 1) begin : g_bad_cfg
    $error("gpu_op_arbiter: unsupported REQ_COUNT/STATS_WIDTH");
  end

  gpu_arb_state_t       state;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     sel;
  logic                 any;
  logic                 locked;
  logic                 pinned;
  logic                 xfer;
  logic [REQ_COUNT-1:0] owner_mask;
  logic [REQ_COUNT-1:0] cand;
  logic [REQ_COUNT-1:0] sel_mask;

  // rr_ptr doubles as the current owner; a held lock narrows the candidates to the owner alone.
  assign owner_mask = REQ_COUNT'(1) << rr_ptr;
  assign pinned     = locked && req_lock[rr_ptr];
  assign cand       = pinned ? (req_valid & owner_mask) : req_valid;

  rr_arbiter_pick #(.REQ_COUNT(REQ_COUNT)) u_pick (
    .valid  (cand),
    .rr_ptr (rr_ptr),
    .sel    (sel),
    .any    (any)
  );

  assign sel_mask  = REQ_COUNT'(1) << sel;
  assign xfer      = (state == IDLE) && op_ready && any;
  assign req_ready = xfer ? sel_mask : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= WAIT_DONE;
      rr_ptr   <= PTR_W'(REQ_COUNT - 1);
      locked   <= 1'b0;
      op       <= '0;
      op_valid <= 1'b0;
      grant    <= '0;
      busy     <= 1'b0;
    end else if (ce) begin
      case (state)
        IDLE: begin
          if (xfer) begin
            op       <= req_op[sel];
            op_valid <= 1'b1;
            grant    <= sel_mask;
            rr_ptr   <= sel;
            locked   <= req_lock[sel];
            busy     <= 1'b1;
            state    <= ISSUE;
          end else if (locked && !req_lock[rr_ptr]) begin
            locked <= 1'b0;
          end
        end
        ISSUE: begin
          op_valid <= 1'b0;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: state <= WAIT_DONE;
        WAIT_DONE: begin
          if (op_ready) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= WAIT_DONE;
      endcase
    end
  end

`ifdef GPU_OP_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else if (ce && xfer && (op_count != '1)) begin
      op_count <= op_count + STATS_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_gpu_op_arbiter.sv
// Self-checking bench for gpu_op_arbiter: directed scenarios with literal expectations followed by
// randomized traffic checked every cycle against a transaction-level model.
module tb_gpu_op_arbiter;
  import gpu_op_arbiter_pkg::*;

  localparam int N    = 3;
  localparam int SW   = 16;
  localparam int MAXC = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst, ce, op_ready, op_valid, busy;
  gpu_op_t       req_op [N];
  gpu_op_t       op;
  logic [N-1:0]  req_valid, req_lock, req_ready, grant;
  logic [SW-1:0] op_count;

  always #5 clk = ~clk;

  gpu_op_arbiter #(.REQ_COUNT(N), .STATS_WIDTH(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .req_op    (req_op),
    .req_valid (req_valid),
    .req_lock  (req_lock),
    .req_ready (req_ready),
    .grant     (grant),
    .op        (op),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .busy      (busy)
`ifdef GPU_OP_ARBITER_STATS_EN
    ,
    .op_count  (op_count)
`endif
  );

`ifndef GPU_OP_ARBITER_STATS_EN
  initial op_count = '0;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  // Transaction-level model: idle flag, cooldown before polling op_ready, owner and lock.
  int           m_owner, m_hold, m_sel, m_cnt;
  bit           m_idle, m_locked, m_op_valid, m_busy;
  gpu_op_t      m_op;
  logic [N-1:0] m_grant, m_ready_exp, m_xfer;

  logic         s_op_valid, s_busy;
  logic [N-1:0] s_grant, s_ready;
  gpu_op_t      s_op;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = N - 1; m_locked = 0; m_idle = 0; m_hold = 0;
    m_op = '0; m_op_valid = 0; m_grant = '0; m_busy = 0; m_cnt = 0;
  endtask

  task automatic model_predict();
    m_sel = -1;
    if (m_locked && req_lock[m_owner]) begin
      if (req_valid[m_owner]) m_sel = m_owner;
    end else begin
      for (int k = 1; k <= N; k++) begin
        automatic int idx = (m_owner + k) % N;
        if (m_sel < 0 && req_valid[idx]) m_sel = idx;
      end
    end
    m_ready_exp = (m_idle && op_ready && m_sel >= 0) ? (N'(1) << m_sel) : '0;
  endtask

  task automatic model_edge();
    m_xfer = '0;
    if (rst) begin
      model_reset();
    end else if (ce) begin
      if (m_idle) begin
        if (m_ready_exp != '0) begin
          m_op = req_op[m_sel]; m_op_valid = 1; m_grant = m_ready_exp;
          m_owner = m_sel; m_locked = req_lock[m_sel]; m_busy = 1;
          m_idle = 0; m_hold = 2; m_xfer = m_ready_exp;
          if (m_cnt < MAXC) m_cnt++;
        end else if (m_locked && !req_lock[m_owner]) begin
          m_locked = 0;
        end
      end else begin
        m_op_valid = 0;
        if (m_hold > 0) m_hold--;
        else if (op_ready) begin m_busy = 0; m_idle = 1; end
      end
    end
  endtask

  // One clock: compare just after the falling edge, then advance the model on the rising edge.
  task automatic cycle();
    #1;
    model_predict();
    check("req_ready", req_ready, m_ready_exp);
    check("grant", grant, m_grant);
    check("op", op, m_op);
    check("op_valid", op_valid, m_op_valid);
    check("busy", busy, m_busy);
`ifdef GPU_OP_ARBITER_STATS_EN
    check("op_count", op_count, m_cnt);
`endif
    s_op_valid = op_valid; s_busy = busy; s_grant = grant; s_ready = req_ready; s_op = op;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; ce = 1;
    cycle();
    rst = 0;
  endtask

  task automatic wait_op(input int budget, output int cyc);
    cyc = 0;
    for (int i = 1; i <= budget; i++) begin
      cycle();
      if (s_op_valid) begin cyc = i; return; end
    end
    n_cmp++; n_fail++;
    $display("FAIL wait_op: no op_valid within %0d cycles, required one", budget);
  endtask

  logic [N-1:0] exp_g2 [4];
  logic [N-1:0] exp_g3 [5];
  int cyc, last_rise, rises;
  logic prev_v;

  initial begin
    rst = 1; ce = 1; op_ready = 1; req_valid = '0; req_lock = '0;
    for (int r = 0; r < N; r++) req_op[r] = gpu_op_t'(32'h0100_0000 * (r + 1));
    model_reset(); m_xfer = '0;
    @(negedge clk);

    // Single requester from reset.
    req_op[0].x = 10'd5; req_valid = 3'b001;
    cycle(); cycle(); rst = 0;
    cycle(); check("t1_ready_in_wait_done", s_ready, 3'b000);
    cycle(); check("t1_ready_idle", s_ready, 3'b001);
    req_valid = '0;
    cycle();
    check("t1_op_valid", s_op_valid, 1'b1);
    check("t1_op_x", s_op.x, 10'd5);
    check("t1_grant", s_grant, 3'b001);
    cycle(); check("t1_pulse_end", s_op_valid, 1'b0);

    // Two requesters contending, always-ready GPU.
    exp_g2[0] = 3'b001; exp_g2[1] = 3'b010; exp_g2[2] = 3'b001; exp_g2[3] = 3'b010;
    do_reset();
    req_valid = 3'b011;
    for (int i = 0; i < 4; i++) begin
      wait_op(30, cyc);
      check("t2_grant", s_grant, exp_g2[i]);
      if (i > 0) check("t2_gap", cyc, 4);
    end
    req_valid = '0;

    // Locked burst from requester 1 starves requester 0 until released.
    exp_g3[0] = 3'b001; exp_g3[1] = 3'b010; exp_g3[2] = 3'b010; exp_g3[3] = 3'b010; exp_g3[4] = 3'b001;
    do_reset();
    req_valid = 3'b011; req_lock = 3'b010;
    for (int i = 0; i < 5; i++) begin
      wait_op(30, cyc);
      check("t3_grant", s_grant, exp_g3[i]);
      if (i == 3) req_lock = '0;
    end
    req_valid = '0;

    // GPU stalls for 20 cycles after an op.
    do_reset();
    req_valid = 3'b001;
    wait_op(30, cyc);
    op_ready = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      check("t4_busy", s_busy, 1'b1);
      check("t4_no_ready", s_ready, 3'b000);
      check("t4_no_op", s_op_valid, 1'b0);
    end
    op_ready = 1;
    wait_op(30, cyc);
    check("t4_resume_latency", cyc, 3);
    req_valid = '0;

    // Clock enable toggling: spacing doubles in clocks.
    do_reset();
    req_valid = 3'b011; prev_v = 0; rises = 0; last_rise = 0;
    for (int i = 0; i < 100 && rises < 3; i++) begin
      ce = ~ce;
      cycle();
      if (s_op_valid && !prev_v) begin
        if (rises > 0) check("t5_gap_clk", i - last_rise, 8);
        last_rise = i; rises++;
      end
      prev_v = s_op_valid;
    end
    check("t5_rises", rises, 3);
    ce = 1; req_valid = '0;

    // Reset while waiting on a locked owner.
    do_reset();
    req_valid = 3'b010; req_lock = 3'b010;
    wait_op(30, cyc);
    op_ready = 0;
    cycle(); cycle(); cycle();
    rst = 1; cycle(); rst = 0;
    cycle();
    check("t6_op_valid", s_op_valid, 1'b0);
    check("t6_grant", s_grant, 3'b000);
    check("t6_busy", s_busy, 1'b0);
    check("t6_op", s_op, 32'h0);
`ifdef GPU_OP_ARBITER_STATS_EN
    check("t6_count", op_count, 16'h0);
`endif
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t6_no_ready", s_ready, 3'b000);
    end
    op_ready = 1;
    wait_op(30, cyc);
    check("t6_latency", cyc, 3);
    check("t6_regrant", s_grant, 3'b010);
    req_valid = '0; req_lock = '0;

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst      = ($urandom_range(0, 299) == 0);
      ce       = ($urandom_range(0, 3) != 0);
      op_ready = ($urandom_range(0, 3) != 0);
      for (int r = 0; r < N; r++) begin
        if (m_xfer[r] || !req_valid[r]) begin
          req_valid[r] = $urandom_range(0, 1) == 1;
          req_op[r]    = gpu_op_t'($urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[r] = 0;
        end
        if ($urandom_range(0, 7) == 0) req_lock[r] = ~req_lock[r];
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
